// File: rtl/enemy_row_controller.sv
// Owns one enemy's alive flag, position and sweep phase; divides the clock into
// move strobes and registers the position returned by the downstream move stage.
module enemy_row_controller #(
    parameter logic [23:0] MOVE_PERIOD       = 24'd833_333,
    parameter logic [5:0]  STEPS_PER_PHASE   = 6'd32,
    parameter logic [9:0]  START_X           = 10'd96,
    parameter logic [8:0]  VERTICAL_POSITION = 9'd168,
    parameter logic [18:0] NONE              = 19'h7FFFF
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Enable,
    input  logic        i_Hit,
    input  logic        i_Respawn,
    input  logic [18:0] i_NextPosition,
    output logic        o_EnemyState,
    output logic [18:0] o_EnemyPosition,
    output logic [1:0]  o_PhaseState,
    output logic        o_MoveTick,
    output logic        o_Killed
);

    localparam logic [1:0] PHASE_LEFT_OUT   = 2'b00;
    localparam logic [1:0] PHASE_RIGHT_BACK = 2'b01;
    localparam logic [1:0] PHASE_RIGHT_OUT  = 2'b10;
    localparam logic [1:0] PHASE_LEFT_BACK  = 2'b11;

    localparam logic [18:0] SPAWN_POSITION = {START_X, VERTICAL_POSITION};

    logic [23:0] cycleCount;
    logic [5:0]  stepCount;
    logic        periodDone;
    logic        phaseDone;
    logic        hitAccepted;
    logic        restart;
    logic [1:0]  nextPhase;

    always_comb begin
        periodDone  = (cycleCount == MOVE_PERIOD - 24'd1);
        phaseDone   = (stepCount == STEPS_PER_PHASE - 6'd1);
        hitAccepted = i_Hit && o_EnemyState;
        restart     = !i_Rst_n || i_Respawn;
    end

    always_comb begin
        nextPhase = PHASE_LEFT_OUT;
        case (o_PhaseState)
            PHASE_LEFT_OUT:   nextPhase = PHASE_RIGHT_BACK;
            PHASE_RIGHT_BACK: nextPhase = PHASE_RIGHT_OUT;
            PHASE_RIGHT_OUT:  nextPhase = PHASE_LEFT_BACK;
            PHASE_LEFT_BACK:  nextPhase = PHASE_LEFT_OUT;
            default:          nextPhase = PHASE_LEFT_OUT;
        endcase
    end

    // Strobe generator: the counter freezes while disabled, but a tick already
    // loaded still lasts its single cycle.
    always_ff @(posedge i_Clk) begin
        if (restart) begin
            cycleCount <= '0;
            o_MoveTick <= 1'b0;
        end else if (i_Enable) begin
            if (periodDone) begin
                cycleCount <= '0;
                o_MoveTick <= 1'b1;
            end else begin
                cycleCount <= cycleCount + 24'd1;
                o_MoveTick <= 1'b0;
            end
        end else begin
            o_MoveTick <= 1'b0;
        end
    end

    // Step and phase advance on every strobe, alive or dead, to keep the row in lockstep.
    always_ff @(posedge i_Clk) begin
        if (restart) begin
            stepCount    <= '0;
            o_PhaseState <= PHASE_LEFT_OUT;
        end else if (o_MoveTick) begin
            if (phaseDone) begin
                stepCount    <= '0;
                o_PhaseState <= nextPhase;
            end else begin
                stepCount <= stepCount + 6'd1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (restart) begin
            o_EnemyState    <= 1'b1;
            o_EnemyPosition <= SPAWN_POSITION;
            o_Killed        <= 1'b0;
        end else if (hitAccepted) begin
            o_EnemyState    <= 1'b0;
            o_EnemyPosition <= NONE;
            o_Killed        <= 1'b1;
        end else begin
            o_Killed <= 1'b0;
            if (o_MoveTick && o_EnemyState) begin
                o_EnemyPosition <= i_NextPosition;
            end
        end
    end

endmodule

// File: tb/tb_enemy_row_controller.sv
// Bench for enemy_row_controller: directed vector table, hand sequences and a
// randomized run checked every cycle against a strobe-counting reference model.
module tb_enemy_row_controller;

    localparam int MP = 4;
    localparam int SP = 2;
    localparam logic [18:0] NONE_POS = 19'h7FFFF;
    localparam logic [8:0]  ROW_Y = 9'd168;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        enable = 1'b0;
    logic        hit = 1'b0;
    logic        respawn = 1'b0;
    logic [18:0] nextPos;
    logic        enemyState;
    logic [18:0] enemyPos;
    logic [1:0]  phaseState;
    logic        moveTick;
    logic        killed;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    enemy_row_controller #(
        .MOVE_PERIOD(24'd4),
        .STEPS_PER_PHASE(6'd2)
    ) dut (
        .i_Clk(clk),
        .i_Rst_n(rstN),
        .i_Enable(enable),
        .i_Hit(hit),
        .i_Respawn(respawn),
        .i_NextPosition(nextPos),
        .o_EnemyState(enemyState),
        .o_EnemyPosition(enemyPos),
        .o_PhaseState(phaseState),
        .o_MoveTick(moveTick),
        .o_Killed(killed)
    );

    // Loopback move stage: left in phases 00/11, right in 01/10.
    always_comb begin
        nextPos = enemyPos;
        if (phaseState == 2'b00 || phaseState == 2'b11)
            nextPos[18:9] = enemyPos[18:9] - 10'd1;
        else
            nextPos[18:9] = enemyPos[18:9] + 10'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: counts enabled cycles and completed strobes since the last restart.
    bit mValid = 0;
    bit mAlive = 1;
    bit mTick = 0;
    bit mKilled = 0;
    int mEnabled = 0;
    int mStrobes = 0;

    function automatic int sweepOffset(input int strobes);
        int off = 0;
        for (int s = 0; s < strobes; s++) begin
            int ph = (s / SP) % 4;
            off += (ph == 0 || ph == 3) ? -1 : 1;
        end
        return off;
    endfunction

    always @(posedge clk) begin
        if (!rstN || respawn) begin
            if (!rstN) mValid = 1;
            mEnabled = 0;
            mStrobes = 0;
            mAlive = 1;
            mTick = 0;
            mKilled = 0;
        end else begin
            if (mTick) mStrobes++;
            mKilled = mAlive && hit;
            if (hit) mAlive = 0;
            if (enable) begin
                mEnabled++;
                mTick = (mEnabled % MP == 0);
            end else begin
                mTick = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (mValid) begin
            logic [9:0]  ex;
            logic [18:0] ep;
            ex = 10'(96 + sweepOffset(mStrobes));
            ep = mAlive ? {ex, ROW_Y} : NONE_POS;
            check("mon_tick", 32'(moveTick), 32'(mTick));
            check("mon_alive", 32'(enemyState), 32'(mAlive));
            check("mon_pos", 32'(enemyPos), 32'(ep));
            check("mon_phase", 32'(phaseState), 32'((mStrobes / SP) % 4));
            check("mon_killed", 32'(killed), 32'(mKilled));
        end
    end

    typedef struct {
        int         n;
        logic       rstN, en, hit, resp;
        logic       expTick, expAlive;
        logic [9:0] expX;
        logic [1:0] expPhase;
        logic       expKilled;
    } vec_t;

    vec_t vecs[30];

    task automatic runTable();
        for (int i = 0; i < 30; i++) begin
            logic [18:0] ep;
            rstN = vecs[i].rstN;
            enable = vecs[i].en;
            hit = vecs[i].hit;
            respawn = vecs[i].resp;
            repeat (vecs[i].n) @(negedge clk);
            ep = vecs[i].expAlive ? {vecs[i].expX, ROW_Y} : NONE_POS;
            check($sformatf("vec%0d_tick", i), 32'(moveTick), 32'(vecs[i].expTick));
            check($sformatf("vec%0d_alive", i), 32'(enemyState), 32'(vecs[i].expAlive));
            check($sformatf("vec%0d_pos", i), 32'(enemyPos), 32'(ep));
            check($sformatf("vec%0d_phase", i), 32'(phaseState), 32'(vecs[i].expPhase));
            check($sformatf("vec%0d_killed", i), 32'(killed), 32'(vecs[i].expKilled));
        end
        hit = 0;
        respawn = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //         n  rst en hit rsp tick alive x       ph     kill
        vecs[0]  = '{2,  0, 0, 0, 0,  0, 1, 10'd96, 2'd0, 0};
        vecs[1]  = '{3,  1, 1, 0, 0,  0, 1, 10'd96, 2'd0, 0};
        vecs[2]  = '{1,  1, 1, 0, 0,  1, 1, 10'd96, 2'd0, 0};
        vecs[3]  = '{1,  1, 1, 0, 0,  0, 1, 10'd95, 2'd0, 0};
        vecs[4]  = '{4,  1, 1, 0, 0,  0, 1, 10'd94, 2'd1, 0};
        vecs[5]  = '{4,  1, 1, 0, 0,  0, 1, 10'd95, 2'd1, 0};
        vecs[6]  = '{4,  1, 1, 0, 0,  0, 1, 10'd96, 2'd2, 0};
        vecs[7]  = '{4,  1, 1, 0, 0,  0, 1, 10'd97, 2'd2, 0};
        vecs[8]  = '{4,  1, 1, 0, 0,  0, 1, 10'd98, 2'd3, 0};
        vecs[9]  = '{4,  1, 1, 0, 0,  0, 1, 10'd97, 2'd3, 0};
        vecs[10] = '{4,  1, 1, 0, 0,  0, 1, 10'd96, 2'd0, 0};
        vecs[11] = '{1,  1, 1, 1, 0,  0, 0, 10'd0,  2'd0, 1};
        vecs[12] = '{1,  1, 1, 0, 0,  0, 0, 10'd0,  2'd0, 0};
        vecs[13] = '{1,  1, 1, 1, 0,  1, 0, 10'd0,  2'd0, 0};
        vecs[14] = '{1,  1, 1, 0, 0,  0, 0, 10'd0,  2'd0, 0};
        vecs[15] = '{4,  1, 1, 0, 0,  0, 0, 10'd0,  2'd1, 0};
        vecs[16] = '{8,  1, 1, 0, 0,  0, 0, 10'd0,  2'd2, 0};
        vecs[17] = '{1,  1, 1, 0, 1,  0, 1, 10'd96, 2'd0, 0};
        vecs[18] = '{2,  1, 1, 0, 0,  0, 1, 10'd96, 2'd0, 0};
        vecs[19] = '{10, 1, 0, 0, 0,  0, 1, 10'd96, 2'd0, 0};
        vecs[20] = '{1,  1, 1, 0, 0,  0, 1, 10'd96, 2'd0, 0};
        vecs[21] = '{1,  1, 1, 0, 0,  1, 1, 10'd96, 2'd0, 0};
        vecs[22] = '{1,  1, 1, 0, 0,  0, 1, 10'd95, 2'd0, 0};
        vecs[23] = '{3,  1, 1, 0, 0,  1, 1, 10'd95, 2'd0, 0};
        vecs[24] = '{1,  1, 1, 1, 0,  0, 0, 10'd0,  2'd1, 1};
        vecs[25] = '{1,  1, 1, 0, 1,  0, 1, 10'd96, 2'd0, 0};
        vecs[26] = '{27, 1, 1, 0, 0,  0, 1, 10'd98, 2'd3, 0};
        vecs[27] = '{1,  0, 1, 0, 0,  0, 1, 10'd96, 2'd0, 0};
        vecs[28] = '{1,  1, 1, 0, 0,  0, 1, 10'd96, 2'd0, 0};
        vecs[29] = '{3,  1, 1, 0, 0,  1, 1, 10'd96, 2'd0, 0};

        @(negedge clk);
        runTable();

        // Strobe spacing: one-cycle tick on every 4th enabled edge.
        rstN = 0; enable = 1;
        @(negedge clk);
        rstN = 1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            check($sformatf("spacing_c%0d", i), 32'(moveTick), 32'(i % MP == 0));
        end

        // A registered strobe completes even if enable drops in its cycle.
        rstN = 0;
        @(negedge clk);
        rstN = 1;
        repeat (4) @(negedge clk);
        check("late_tick", 32'(moveTick), 32'd1);
        enable = 0;
        @(negedge clk);
        check("late_pos", 32'(enemyPos), 32'({10'd95, ROW_Y}));
        check("late_tick_clear", 32'(moveTick), 32'd0);
        repeat (5) @(negedge clk);
        check("hold_tick", 32'(moveTick), 32'd0);
        check("hold_pos", 32'(enemyPos), 32'({10'd95, ROW_Y}));
        enable = 1;
        repeat (3) @(negedge clk);
        check("resume_no_tick", 32'(moveTick), 32'd0);
        @(negedge clk);
        check("resume_tick", 32'(moveTick), 32'd1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            rstN = ($urandom_range(0, 499) != 0);
            enable = ($urandom_range(0, 9) != 0);
            hit = ($urandom_range(0, 39) == 0);
            respawn = ($urandom_range(0, 149) == 0);
            @(negedge clk);
        end
        rstN = 1; enable = 0; hit = 0; respawn = 0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
